// File: rtl/phy_tx_scheduler.sv
// Transmit scheduler in front of the phy. After reset it sends a COM training preamble,
// then arbitrates four requesters round-robin with a burst limit. Output is registered; gnt is combinational.
module phy_tx_scheduler #(
  parameter int          TRAIN_CYCLES = 4,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  IDLE_SYM     = 8'h7C,
  parameter int          MAX_BURST    = 4
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [8:0] in0,
  input  logic [8:0] in1,
  input  logic [8:0] in2,
  input  logic [8:0] in3,
  input  logic       pause,
  output logic [3:0] gnt,
  output logic [8:0] data_out,
  output logic [1:0] lane_id,
  output logic       active
);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_CYCLES - 1);
  localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] train_cnt;
  logic [1:0] next_ptr;      // lane after the last granted one; reset 0 means c = 3
  logic [3:0] burst_cnt;
  logic [1:0] cur;
  logic [1:0] idx;
  logic [1:0] gnt_lane;
  logic       gnt_vld;
  logic [7:0] lane_dat [4];

  assign cur = next_ptr - 2'd1;

  // Valid bits of the inputs are regenerated on output, so only data bits are muxed.
  assign lane_dat[0] = in0[7:0];
  assign lane_dat[1] = in1[7:0];
  assign lane_dat[2] = in2[7:0];
  assign lane_dat[3] = in3[7:0];
  logic unused_msb;
  assign unused_msb = &{1'b0, in0[8], in1[8], in2[8], in3[8]};

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_lane  = cur;
    idx       = cur;
    case (state)
      TRAIN: begin
        if (train_cnt == TRAIN_LAST) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!pause && (req != 4'b0000)) begin
          // burst_cnt == 0 means nothing granted yet, so there is no lane to stick to
          if ((burst_cnt != 4'd0) && req[cur] && (burst_cnt < BURST_MAX)) begin
            gnt_vld  = 1'b1;
            gnt_lane = cur;
          end else begin
            for (int k = 1; k <= 4; k++) begin
              idx = cur + 2'(k);
              if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_lane = idx;
              end
            end
          end
        end
      end
      default: state_nxt = TRAIN;
    endcase
    if (reset) gnt_vld = 1'b0;
    gnt = gnt_vld ? (4'b0001 << gnt_lane) : 4'b0000;
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      state     <= TRAIN;
      train_cnt <= 4'd0;
      next_ptr  <= 2'd0;
      burst_cnt <= 4'd0;
      data_out  <= 9'h000;
      lane_id   <= 2'd0;
      active    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == TRAIN) begin
        data_out  <= {1'b1, COM_SYM};
        lane_id   <= 2'd0;
        train_cnt <= train_cnt + 4'd1;
        if (state_nxt == ACTIVE) active <= 1'b1;
      end else if (gnt_vld) begin
        data_out <= {1'b1, lane_dat[gnt_lane]};
        lane_id  <= gnt_lane;
        if (gnt_lane == cur) begin
          if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
        end else begin
          next_ptr  <= gnt_lane + 2'd1;
          burst_cnt <= 4'd1;
        end
      end else begin
        data_out <= {1'b0, IDLE_SYM};
      end
    end
  end

endmodule
